// File: rtl/playback_sequencer.sv
`default_nettype none
// ============================================================================
// playback_sequencer : steps through stored note slots, waits out the memory
//                      read latency and plays each note as a square wave.
// Revision 1.0
// ============================================================================
module playback_sequencer #(
    parameter int unsigned NOTE_CYCLES = 32'd12_500_000,
    parameter int unsigned GAP_CYCLES  = 32'd500_000,
    parameter int unsigned READ_LAT    = 32'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [4:0]  num_notes,
    input  logic [31:0] freq_in,
    output logic        ld_play,
    output logic [3:0]  note_counter,
    output logic        busy,
    output logic        note_valid,
    output logic        done,
    output logic        audio_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_PLAY = 3'd3,
        S_GAP  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [31:0] C_NOTE_LAST = 32'(NOTE_CYCLES - 1);
    localparam logic [31:0] C_WAIT_LAST = 32'(READ_LAT - 1);
    localparam logic [31:0] C_GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
    localparam logic        C_HAS_GAP   = (GAP_CYCLES != 0);

    state_t      r_state;
    logic [3:0]  r_last;
    logic [31:0] r_cnt;
    logic [31:0] r_tone_cnt;
    logic [31:0] r_half_period;

    logic w_play_end;
    logic w_advance;

    // r_cnt is shared by WAIT, PLAY and GAP since only one is active at a time
    assign w_play_end = (r_state == S_PLAY) && (r_cnt == C_NOTE_LAST);
    assign w_advance  = (w_play_end && !C_HAS_GAP) ||
                        ((r_state == S_GAP) && (r_cnt == C_GAP_LAST));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_last        <= 4'd0;
            r_cnt         <= 32'd0;
            r_tone_cnt    <= 32'd0;
            r_half_period <= 32'd0;
            ld_play       <= 1'b0;
            note_counter  <= 4'd0;
            busy          <= 1'b0;
            note_valid    <= 1'b0;
            done          <= 1'b0;
            audio_out     <= 1'b0;
        end else if ((r_state != S_IDLE) && stop) begin
            r_state    <= S_IDLE;
            r_cnt      <= 32'd0;
            r_tone_cnt <= 32'd0;
            ld_play    <= 1'b0;
            busy       <= 1'b0;
            note_valid <= 1'b0;
            done       <= 1'b0;
            audio_out  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (num_notes != 5'd0) begin
                            r_last       <= (num_notes > 5'd16) ? 4'd15 : 4'(num_notes - 5'd1);
                            note_counter <= 4'd0;
                            ld_play      <= 1'b1;
                            busy         <= 1'b1;
                            r_state      <= S_ADDR;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    r_cnt   <= 32'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == C_WAIT_LAST) begin
                        r_half_period <= freq_in;
                        r_cnt         <= 32'd0;
                        r_tone_cnt    <= 32'd0;
                        audio_out     <= 1'b0;
                        note_valid    <= 1'b1;
                        r_state       <= S_PLAY;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_PLAY: begin
                    // a zero half-period is a rest: output held low
                    if (r_half_period == 32'd0) begin
                        audio_out <= 1'b0;
                    end else if (r_tone_cnt == r_half_period - 32'd1) begin
                        r_tone_cnt <= 32'd0;
                        audio_out  <= ~audio_out;
                    end else begin
                        r_tone_cnt <= r_tone_cnt + 32'd1;
                    end
                    if (w_play_end) begin
                        r_cnt      <= 32'd0;
                        note_valid <= 1'b0;
                        audio_out  <= 1'b0;
                        r_state    <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    r_cnt <= r_cnt + 32'd1;
                end
                S_FIN: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // next-note decision overrides the PLAY/GAP exit chosen above
            if (w_advance) begin
                r_cnt <= 32'd0;
                if (note_counter == r_last) begin
                    done    <= 1'b1;
                    ld_play <= 1'b0;
                    r_state <= S_FIN;
                end else begin
                    note_counter <= note_counter + 4'd1;
                    r_state      <= S_ADDR;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_playback_sequencer.sv
`default_nettype none
// ============================================================================
// tb_playback_sequencer : scoreboard bench for playback_sequencer.
// Revision 1.0
// ============================================================================
module tb_playback_sequencer;

    localparam int NC = 20;
    localparam int GC = 4;
    localparam int RL = 2;
    localparam int PN = 1 + RL + NC + GC;

    localparam int K_LD   = 0;
    localparam int K_BUSY = 1;
    localparam int K_NC   = 2;
    localparam int K_PLAY = 3;
    localparam int K_TOG  = 4;
    localparam int K_DONE = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [4:0]  num_notes;
    logic [31:0] freq_in;
    logic        ld_play;
    logic [3:0]  note_counter;
    logic        busy;
    logic        note_valid;
    logic        done;
    logic        audio_out;

    always #5 clk = ~clk;

    playback_sequencer #(
        .NOTE_CYCLES(NC),
        .GAP_CYCLES (GC),
        .READ_LAT   (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .num_notes   (num_notes),
        .freq_in     (freq_in),
        .ld_play     (ld_play),
        .note_counter(note_counter),
        .busy        (busy),
        .note_valid  (note_valid),
        .done        (done),
        .audio_out   (audio_out)
    );

    // Note memory with two-cycle read latency
    logic [31:0] mem [16];
    logic [31:0] rd_p1;
    always @(posedge clk) begin
        rd_p1   <= mem[note_counter];
        freq_in <= rd_p1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b0;

    logic       p_ld, p_busy, p_nv, p_audio;
    logic [3:0] p_nc;

    function automatic string kname(input int k);
        case (k)
            K_LD:    return "ld_play";
            K_BUSY:  return "busy";
            K_NC:    return "note_counter";
            K_PLAY:  return "play_start";
            K_TOG:   return "audio_out";
            default: return "done";
        endcase
    endfunction

    task automatic push(input int k, input int at, input int v);
        ev_t e;
        e.kind = k;
        e.at   = at;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input int v);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got %s at cycle %0d value %0d, expected no event", kname(k), cyc, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc || e.val != v) begin
                bad++;
                $display("FAIL event: got %s at cycle %0d value %0d, expected %s at cycle %0d value %0d",
                         kname(k), cyc, v, kname(e.kind), e.at, e.val);
            end
        end
    endtask

    // Monitor: turns output changes into events and scores them against the queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (ld_play !== p_ld)        check_ev(K_LD, int'(ld_play));
            if (busy !== p_busy)         check_ev(K_BUSY, int'(busy));
            if (note_counter !== p_nc)   check_ev(K_NC, int'(note_counter));
            if (note_valid && !p_nv)     check_ev(K_PLAY, int'(note_counter));
            if (audio_out !== p_audio)   check_ev(K_TOG, int'(audio_out));
            if (done === 1'b1)           check_ev(K_DONE, int'(note_counter));
        end
        p_ld    <= ld_play;
        p_busy  <= busy;
        p_nc    <= note_counter;
        p_nv    <= note_valid;
        p_audio <= audio_out;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expected events for a normal run of n notes started at cycle e
    task automatic expect_run(input int e, input int n, input int prev_nc);
        int a, p, h, v, pv, fin;
        push(K_LD, e + 1, 1);
        push(K_BUSY, e + 1, 1);
        if (prev_nc != 0) push(K_NC, e + 1, 0);
        for (int i = 0; i < n; i++) begin
            a = e + 1 + i * PN;
            if (i > 0) push(K_NC, a, i);
            p = a + 1 + RL;
            push(K_PLAY, p, i);
            h  = int'(mem[i]);
            pv = 0;
            for (int k = 0; k < NC; k++) begin
                v = (h == 0) ? 0 : ((k / h) % 2);
                if (v != pv) push(K_TOG, p + k, v);
                pv = v;
            end
            if (pv != 0) push(K_TOG, p + NC, 0);
        end
        fin = e + 1 + n * PN;
        push(K_LD, fin, 0);
        push(K_DONE, fin, n - 1);
        push(K_BUSY, fin + 1, 0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        step(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int dc;
        reset     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        num_notes = 5'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;

        // Reset values
        step(3);
        chk("reset ld_play", int'(ld_play), 0);
        chk("reset note_counter", int'(note_counter), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset note_valid", int'(note_valid), 0);
        chk("reset done", int'(done), 0);
        chk("reset audio_out", int'(audio_out), 0);
        reset = 1'b1;
        step(1);
        mon_en = 1'b1;
        step(2);

        // One note, half-period 3
        mem[0]    = 32'd3;
        num_notes = 5'd1;
        start     = 1'b1;
        e         = cyc;
        push(K_LD, e + 1, 1);
        push(K_BUSY, e + 1, 1);
        push(K_PLAY, e + 4, 0);
        push(K_TOG, e + 7, 1);
        push(K_TOG, e + 10, 0);
        push(K_TOG, e + 13, 1);
        push(K_TOG, e + 16, 0);
        push(K_TOG, e + 19, 1);
        push(K_TOG, e + 22, 0);
        push(K_LD, e + 28, 0);
        push(K_DONE, e + 28, 0);
        push(K_BUSY, e + 29, 0);
        step(1);
        start = 1'b0;
        chk("addr ld_play", int'(ld_play), 1);
        chk("addr busy", int'(busy), 1);
        chk("addr note_counter", int'(note_counter), 0);
        drain(100);

        // Three notes 2, 0 (rest), 5
        mem[0]    = 32'd2;
        mem[1]    = 32'd0;
        mem[2]    = 32'd5;
        num_notes = 5'd3;
        start     = 1'b1;
        e         = cyc;
        expect_run(e, 3, 0);
        step(1);
        start = 1'b0;
        dc    = -1;
        for (int i = 0; i < 120 && dc < 0; i++) begin
            if (done === 1'b1) dc = cyc;
            else step(1);
        end
        chk("three-note done cycle", dc - e, 82);
        drain(50);

        // num_notes=20 clamps to 16; start and stop together in IDLE
        for (int i = 0; i < 16; i++) mem[i] = 32'((i % 3) + 1);
        num_notes = 5'd20;
        start     = 1'b1;
        stop      = 1'b1;
        e         = cyc;
        expect_run(e, 16, 2);
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        drain(16 * PN + 20);
        chk("clamped final note_counter", int'(note_counter), 15);

        // num_notes=0: immediate done, stays idle
        num_notes = 5'd0;
        start     = 1'b1;
        e         = cyc;
        push(K_DONE, e + 1, 15);
        step(1);
        start = 1'b0;
        chk("zero-notes done", int'(done), 1);
        chk("zero-notes busy", int'(busy), 0);
        chk("zero-notes ld_play", int'(ld_play), 0);
        step(1);
        chk("zero-notes done width", int'(done), 0);
        drain(10);

        // Abort mid-PLAY of note 1 while audio is high
        mem[0]    = 32'd4;
        mem[1]    = 32'd3;
        num_notes = 5'd2;
        start     = 1'b1;
        e         = cyc;
        push(K_LD, e + 1, 1);
        push(K_BUSY, e + 1, 1);
        push(K_NC, e + 1, 0);
        push(K_PLAY, e + 4, 0);
        push(K_TOG, e + 8, 1);
        push(K_TOG, e + 12, 0);
        push(K_TOG, e + 16, 1);
        push(K_TOG, e + 20, 0);
        push(K_NC, e + 28, 1);
        push(K_PLAY, e + 31, 1);
        push(K_TOG, e + 34, 1);
        push(K_LD, e + 35, 0);
        push(K_BUSY, e + 35, 0);
        push(K_TOG, e + 35, 0);
        step(1);
        start = 1'b0;
        step(33);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("abort audio_out", int'(audio_out), 0);
        chk("abort ld_play", int'(ld_play), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort note_valid", int'(note_valid), 0);
        chk("abort note_counter", int'(note_counter), 1);
        chk("abort done", int'(done), 0);
        drain(10);

        // Replay after abort restarts from slot 0
        num_notes = 5'd1;
        start     = 1'b1;
        e         = cyc;
        expect_run(e, 1, 1);
        step(1);
        start = 1'b0;
        drain(60);

        // Reset during GAP; a start pulsed while busy is ignored
        mem[0]    = 32'd5;
        mem[1]    = 32'd2;
        num_notes = 5'd2;
        start     = 1'b1;
        e         = cyc;
        push(K_LD, e + 1, 1);
        push(K_BUSY, e + 1, 1);
        push(K_PLAY, e + 4, 0);
        push(K_TOG, e + 9, 1);
        push(K_TOG, e + 14, 0);
        push(K_TOG, e + 19, 1);
        push(K_TOG, e + 24, 0);
        push(K_LD, e + 25, 0);
        push(K_BUSY, e + 25, 0);
        step(1);
        start = 1'b0;
        step(9);
        num_notes = 5'd0;
        start     = 1'b1;
        step(1);
        start = 1'b0;
        step(13);
        reset = 1'b0;
        step(1);
        chk("gap-reset ld_play", int'(ld_play), 0);
        chk("gap-reset note_counter", int'(note_counter), 0);
        chk("gap-reset busy", int'(busy), 0);
        chk("gap-reset note_valid", int'(note_valid), 0);
        chk("gap-reset done", int'(done), 0);
        chk("gap-reset audio_out", int'(audio_out), 0);
        reset = 1'b1;
        step(4);
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
